spi_frame_master: RTL and testbench
===================================

Name: spi_frame_master

Overview:
- Clocked SPI master that produces the 40-bit command+data frame consumed by the FPGA's SPI slave port: 8-bit command, then 32-bit data, MSB first, mode 0 (CPOL=0, CPHA=0).
- Drives sck/mosi/ncs and captures miso into an 8-bit status and a 32-bit read word.
- Sits upstream of the slave, either in a companion FPGA or as the on-chip bus-functional driver for system tests.
- A single start/done handshake to local logic replaces hand-toggled bench stimulus.

Parameters:
- CLK_DIV, 4, clk cycles per sck half-period; legal values are 2 or more.
- CS_GAP, 4, clk cycles that ncs is held high after a frame before a new start is accepted; legal values are 1 or more.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only when busy=0.
- cmd_in  in  8  command byte to transmit.
- data_in  in  32  data word to transmit.
- busy  out  1  high from the edge that accepts start until the end of the CS_GAP period.
- done  out  1  one-cycle pulse when the frame completes.
- stat_out  out  8  first 8 bits received on miso.
- data_out  out  32  last 32 bits received on miso.
- sck  out  1  SPI clock; idles low.
- mosi  out  1  SPI data out.
- ncs  out  1  active-low chip select.
- miso  in  1  SPI data in; asynchronous to clk.

Behaviour:
- Reset values:
  - busy=0, done=0, sck=0, mosi=0, ncs=1.
  - stat_out=0, data_out=0.
  - FSM in IDLE, all counters 0.
- All outputs are registered; no combinational path from any input to any output.
- FSM states:
  - IDLE -> SETUP: taken when start=1. On that edge: latch {cmd_in, data_in} into a 40-bit tx shift register; set ncs=0; set mosi=bit39; set busy=1.
  - SETUP: sck low for CLK_DIV cycles, then -> SHIFT.
  - SHIFT: 40 bit periods. Each period is sck high for CLK_DIV cycles, then sck low for CLK_DIV cycles.
    - miso sampling: miso is sampled on the last clk cycle of each high phase (the edge on which sck returns low), giving the slave CLK_DIV-1 cycles of synchroniser slack.
    - mosi update: on the same edge the tx register shifts left and mosi takes the next bit.
    - After the 40th bit, mosi is driven 0.
  - SHIFT -> GAP: after the 40th low phase completes. On that edge: ncs=1; stat_out = rx[39:32]; data_out = rx[31:0]; done=1 for exactly one cycle.
  - GAP: CS_GAP cycles with ncs=1 and busy=1, then -> IDLE with busy=0.
- Frame timing:
  - ncs is low for exactly 81*CLK_DIV clk cycles.
  - Exactly 40 sck rising edges occur per frame.
  - start-accept edge to done pulse is 81*CLK_DIV cycles.
- Boundary conditions:
  - start while busy=1 is ignored, with no effect on the current frame and no queuing.
  - start held high continuously gives back-to-back frames separated by CS_GAP cycles of ncs high.
  - cmd_in/data_in changes after the accept edge do not affect the frame in flight.
  - stat_out/data_out hold their values until the next done; they never show partial frames.
  - rst mid-frame: ncs rises, sck and mosi drop, busy=0 immediately, no done pulse, and stat_out/data_out are cleared.
- Width rules:
  - Bit counter is 6 bits (0..39).
  - Divider counter is sized $clog2(CLK_DIV) and wraps at CLK_DIV-1.
  - GAP counter is sized $clog2(CS_GAP+1).

Decomposition:
- Shared package spi_pkg:
  - CMD_W=8, DATA_W=32, FRAME_W=40.
  - FSM state enum {IDLE, SETUP, SHIFT, GAP}.
  - Mode-0 polarity constants.
- One sub-module: spi_sck_gen, the divider that emits sck_rise/sck_fall strobes and the registered sck level, enabled by the FSM.
- The shift registers and FSM stay in the top module.

Test Plan:
- Loopback (miso tied to mosi), CLK_DIV=4: cmd 0xA0, data 0x24AF55AA -> stat_out=0xA0, data_out=0x24AF55AA; done exactly one cycle; ncs low 324 cycles; 40 sck rises.
- Loopback, cmd 0x51, data 0x01234567, started 1 cycle after busy falls -> stat_out=0x51, data_out=0x01234567; ncs high for at least CS_GAP cycles between the two frames.
- miso held 1 -> stat_out=0xFF, data_out=0xFFFFFFFF; miso held 0 -> both 0. mosi checked bit-for-bit against cmd/data at each sck rise.
- start pulsed at cycles 10, 50 and 200 of a running frame -> ignored; exactly one done; outputs match the first frame only.
- rst asserted at bit 17 of a frame -> within the same cycle ncs=1, sck=0, busy=0; no done; stat_out=data_out=0; the next start produces a correct full frame.
- CLK_DIV=2, CS_GAP=1 with start held high -> back-to-back frames; ncs low 162 cycles each; done every 162+1+1 cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared widths, FSM encoding and mode-0 idle levels for the SPI frame master.
package spi_pkg;
  localparam int CMD_W     = 8;
  localparam int DATA_W    = 32;
  localparam int FRAME_W   = CMD_W + DATA_W;
  localparam int BIT_CNT_W = 6;

  // Mode 0: sck idles low, chip select idles deasserted (high).
  localparam logic SCK_IDLE = 1'b0;
  localparam logic NCS_IDLE = 1'b1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_e;
endpackage

// File: rtl/spi_sck_gen.sv
// sck divider: toggles every CLK_DIV cycles while enabled, strobes mark the edge sck changes on.
// hold_i suppresses the next rising edge so the frame can end on a low phase.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic hold_i,
  output logic sck_o,
  output logic sck_rise_o,
  output logic sck_fall_o
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic          sck_q;
  logic          phase_end;

  assign phase_end  = en_i && (div_q == DIV_MAX);
  assign sck_rise_o = phase_end && !sck_q;
  assign sck_fall_o = phase_end && sck_q;
  assign sck_o      = sck_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
      sck_q <= SCK_IDLE;
    end else if (!en_i) begin
      div_q <= '0;
      sck_q <= SCK_IDLE;
    end else begin
      div_q <= phase_end ? '0 : div_q + 1'b1;
      if (sck_fall_o)
        sck_q <= 1'b0;
      else if (sck_rise_o && !hold_i)
        sck_q <= 1'b1;
    end
  end
endmodule

// File: rtl/spi_frame_master.sv
// Mode-0 SPI master for one 40-bit cmd+data frame per start; done pulses 81*CLK_DIV cycles after accept.
// start is ignored while busy; busy covers the frame plus CS_GAP cycles of ncs high.
module spi_frame_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CMD_W-1:0]  cmd_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [CMD_W-1:0]  stat_out,
  output logic [DATA_W-1:0] data_out,
  output logic              sck,
  output logic              mosi,
  output logic              ncs,
  input  logic              miso
);
  localparam int GW = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;
  localparam logic [GW-1:0]        GAP_MAX  = GW'(CS_GAP - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_W - 1);

  state_e               state_q;
  logic [FRAME_W-1:0]   tx_q;
  logic [FRAME_W-1:0]   rx_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [GW-1:0]        gap_cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ncs_q;
  logic [CMD_W-1:0]     stat_q;
  logic [DATA_W-1:0]    data_q;

  logic sck_en;
  logic last_bit;
  logic sck_rise;
  logic sck_fall;

  assign sck_en   = (state_q == SETUP) || (state_q == SHIFT);
  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (sck_en),
    .hold_i     (last_bit),
    .sck_o      (sck),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ncs_q     <= NCS_IDLE;
      stat_q    <= '0;
      data_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            tx_q      <= {cmd_in, data_in};
            bit_cnt_q <= '0;
            ncs_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          if (sck_rise)
            state_q <= SHIFT;
        end
        SHIFT: begin
          // Zeros shift in behind the frame, so mosi drops to 0 after the last bit.
          if (sck_fall) begin
            rx_q <= {rx_q[FRAME_W-2:0], miso};
            tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
          end
          if (sck_rise) begin
            if (last_bit) begin
              ncs_q     <= NCS_IDLE;
              done_q    <= 1'b1;
              stat_q    <= rx_q[FRAME_W-1:DATA_W];
              data_q    <= rx_q[DATA_W-1:0];
              gap_cnt_q <= '0;
              state_q   <= GAP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_MAX) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ncs      = ncs_q;
  assign mosi     = tx_q[FRAME_W-1];
  assign stat_out = stat_q;
  assign data_out = data_q;
endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboard bench: stimulus pushes expected frames, negedge monitors pop on done and check timing.
module tb_spi_frame_master;
  localparam int DIV_A = 4;
  localparam int GAP_A = 4;
  localparam int DIV_B = 2;
  localparam int GAP_B = 1;
  localparam int LAT_A = 81 * DIV_A;
  localparam int LAT_B = 81 * DIV_B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a, busy_a, done_a, sck_a, mosi_a, ncs_a, miso_a;
  logic [7:0]  cmd_a, stat_a;
  logic [31:0] data_a, dout_a;
  logic [1:0]  mode_a;
  logic        start_b, busy_b, done_b, sck_b, mosi_b, ncs_b, miso_b;
  logic [7:0]  cmd_b, stat_b;
  logic [31:0] data_b, dout_b;

  // mode 0: slave echoes mosi; mode 1: miso stuck high; mode 2: stuck low
  assign miso_a = (mode_a == 2'd0) ? mosi_a : (mode_a == 2'd1);
  assign miso_b = mosi_b;

  spi_frame_master #(.CLK_DIV(DIV_A), .CS_GAP(GAP_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cmd_in(cmd_a), .data_in(data_a),
    .busy(busy_a), .done(done_a), .stat_out(stat_a), .data_out(dout_a),
    .sck(sck_a), .mosi(mosi_a), .ncs(ncs_a), .miso(miso_a));

  spi_frame_master #(.CLK_DIV(DIV_B), .CS_GAP(GAP_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cmd_in(cmd_b), .data_in(data_b),
    .busy(busy_b), .done(done_b), .stat_out(stat_b), .data_out(dout_b),
    .sck(sck_b), .mosi(mosi_b), .ncs(ncs_b), .miso(miso_b));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  typedef struct packed {
    logic [39:0] frame;
    logic [39:0] exp;
    logic [31:0] acc;
  } ent_t;
  ent_t sbq[$];

  // What the slave side returns, expressed purely from the miso condition.
  function automatic logic [39:0] model(input logic [39:0] frame, input logic [1:0] m);
    if (m == 2'd0) return frame;
    if (m == 2'd1) return {40{1'b1}};
    return '0;
  endfunction

  // ---------------- monitor A ----------------
  int   low_a = 0, hi_a = 0, rise_a = 0, dones_a = 0;
  logic prev_ncs_a = 1'b1, prev_sck_a = 1'b0, prev_done_a = 1'b0, seen_a = 1'b0;
  ent_t e_a;

  always @(negedge clk) begin
    if (rst) begin
      low_a = 0; rise_a = 0;
      prev_ncs_a = 1'b1; prev_sck_a = 1'b0; prev_done_a = 1'b0;
    end else begin
      if (prev_done_a) chk("done_width", done_a, 0);
      if (sck_a && !prev_sck_a) begin
        if (sbq.size() == 0) fail("sck_rise_without_frame");
        else if (rise_a >= 40) fail("extra_sck_rise");
        else chk("mosi_bit", mosi_a, sbq[0].frame[39 - rise_a]);
        rise_a++;
      end
      if (!ncs_a && prev_ncs_a) begin
        if (seen_a) chk("ncs_gap_ge_cs_gap", (hi_a >= GAP_A), 1);
        low_a = 0;
      end
      if (ncs_a && !prev_ncs_a) begin
        chk("ncs_low_cycles", low_a, LAT_A);
        seen_a = 1'b1;
        hi_a = 0;
      end
      if (!ncs_a) low_a++; else hi_a++;
      if (done_a) begin
        dones_a++;
        if (sbq.size() == 0) fail("unexpected_done");
        else begin
          e_a = sbq.pop_front();
          chk("stat_out", stat_a, e_a.exp[39:32]);
          chk("data_out", dout_a, e_a.exp[31:0]);
          chk("accept_to_done", cyc - int'(e_a.acc), LAT_A);
          chk("sck_rises", rise_a, 40);
        end
        rise_a = 0;
      end
      prev_ncs_a  = ncs_a;
      prev_sck_a  = sck_a;
      prev_done_a = done_a;
    end
  end

  // ---------------- monitor B (start held high) ----------------
  int   low_b = 0, dones_b = 0, last_done_b = 0;
  logic prev_ncs_b = 1'b1, have_b = 1'b0;
  logic [7:0]  exp_cmd_b;
  logic [31:0] exp_data_b;

  always @(negedge clk) begin
    if (rst) begin
      low_b = 0; prev_ncs_b = 1'b1; have_b = 1'b0;
    end else begin
      if (ncs_b && !prev_ncs_b) chk("b_ncs_low_cycles", low_b, LAT_B);
      if (!ncs_b && prev_ncs_b) low_b = 0;
      if (!ncs_b) low_b++;
      if (done_b) begin
        chk("b_stat_out", stat_b, exp_cmd_b);
        chk("b_data_out", dout_b, exp_data_b);
        if (have_b) chk("b_done_period", cyc - last_done_b, LAT_B + GAP_B + 1);
        have_b = 1'b1;
        last_done_b = cyc;
        dones_b++;
      end
      prev_ncs_b = ncs_b;
    end
  end

  // ---------------- stimulus ----------------
  int last_acc = 0;

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy_a && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy_a) fail("idle_timeout");
  endtask

  task automatic send(input logic [7:0] c, input logic [31:0] d, input logic [1:0] m, input int pre);
    ent_t e;
    wait_idle();
    repeat (pre) @(negedge clk);
    mode_a  = m;
    cmd_a   = c;
    data_a  = d;
    start_a = 1'b1;
    e.frame = {c, d};
    e.exp   = model({c, d}, m);
    e.acc   = 32'(cyc + 1);
    last_acc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
    cmd_a   = 8'($urandom);
    data_a  = $urandom;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog_expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int offs[3];
    int d0;
    int n;
    offs = '{10, 50, 200};
    start_a = 1'b0; cmd_a = '0; data_a = '0; mode_a = 2'd0;
    start_b = 1'b0; cmd_b = '0; data_b = '0;
    exp_cmd_b = '0; exp_data_b = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_sck", sck_a, 0);
    chk("rst_mosi", mosi_a, 0);
    chk("rst_ncs", ncs_a, 1);
    chk("rst_stat", stat_a, 0);
    chk("rst_data", dout_a, 0);
    chk("rst_b_ncs", ncs_b, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send(8'hA0, 32'h24AF55AA, 2'd0, 2);
    send(8'h51, 32'h01234567, 2'd0, 0);
    send(8'h3C, 32'h5A5A1234, 2'd1, 1);
    send(8'hC3, 32'h89ABCDEF, 2'd2, 1);
    for (int i = 0; i < 6; i++)
      send(8'($urandom), $urandom, 2'($urandom_range(0, 2)), $urandom_range(0, 4));

    // starts during a running frame must be ignored
    send(8'($urandom), $urandom, 2'd0, 1);
    d0 = dones_a - 1 + sbq.size();
    for (int k = 0; k < 3; k++) begin
      while (cyc < last_acc + offs[k]) @(negedge clk);
      start_a = 1'b1;
      cmd_a   = 8'($urandom);
      data_a  = $urandom;
      @(negedge clk);
      start_a = 1'b0;
    end
    wait_idle();
    repeat (30) @(negedge clk);
    chk("ignored_start_dones", dones_a - d0, 1);
    chk("ignored_start_sb_empty", sbq.size(), 0);

    // reset in the middle of a frame
    send(8'($urandom), $urandom | 32'h1, 2'd0, 1);
    n = 0;
    while (rise_a < 17 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (rise_a < 17) fail("bit17_timeout");
    rst = 1'b1;
    #1;
    chk("midrst_ncs", ncs_a, 1);
    chk("midrst_sck", sck_a, 0);
    chk("midrst_mosi", mosi_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_stat", stat_a, 0);
    chk("midrst_data", dout_a, 0);
    sbq.delete();
    d0 = dones_a;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    chk("midrst_no_done", dones_a, d0);
    send(8'h96, 32'hFEDCBA98, 2'd0, 1);
    wait_idle();

    // back-to-back frames on the fast instance
    exp_cmd_b  = 8'($urandom);
    exp_data_b = $urandom;
    cmd_b      = exp_cmd_b;
    data_b     = exp_data_b;
    start_b    = 1'b1;
    n = 0;
    while (dones_b < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("b_three_frames", (dones_b >= 3), 1);
    start_b = 1'b0;
    n = 0;
    while (busy_b && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("b_idle_after_release", busy_b, 0);

    repeat (10) @(negedge clk);
    chk("final_sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
